// File: rtl/fetch_queue_unit.sv
// Sequential fetch-PC generator with one outstanding imem request and a PC/instruction FIFO toward decode.
// Optional FETCH_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module fetch_queue_unit #(
    parameter int              XLEN     = 64,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    input  logic            id_ready
);
    localparam int              PW       = $clog2(DEPTH);
    localparam int              CW       = PW + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);
    localparam logic [XLEN-1:0] ALIGN_M  = ~XLEN'(3);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]     instr_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q    [DEPTH];

    logic resp_take;
    logic byp_take;
    logic fifo_wr;
    logic fifo_rd;

    assign imem_req_addr = fetch_pc_q;

    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        count_d        = count_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        imem_req_valid = 1'b0;
        resp_take      = 1'b0;
        byp_take       = 1'b0;
        fifo_wr        = 1'b0;
        fifo_rd        = 1'b0;
        id_valid       = 1'b0;
        id_instr       = '0;
        id_pc          = '0;

        if (!rst) begin
            id_valid = (count_q != '0);
            id_instr = instr_mem_q[rd_ptr_q];
            id_pc    = pc_mem_q[rd_ptr_q];
        end

        case (state_q)
            S_REQ: begin
                // Slot is reserved at issue time, so a later push can never overflow.
                imem_req_valid = !rst && (count_q < FULL_CNT) && !redirect_valid;
                if (imem_req_valid && imem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    state_d   = S_REQ;
                    resp_take = !redirect_valid;
                end else if (redirect_valid) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_resp_valid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

`ifdef FETCH_BYPASS_EN
        if (resp_take && (count_q == '0) && !rst) begin
            id_valid = 1'b1;
            id_instr = imem_resp_instr;
            id_pc    = fetch_pc_q;
            byp_take = id_ready;
        end
`endif

        fifo_wr = resp_take && !byp_take;
        fifo_rd = !rst && (count_q != '0) && id_ready && !redirect_valid;

        if (resp_take) fetch_pc_d = fetch_pc_q + XLEN'(4);
        if (fifo_wr)   wr_ptr_d   = wr_ptr_q + PW'(1);
        if (fifo_rd)   rd_ptr_d   = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(fifo_wr) - CW'(fifo_rd);

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ALIGN_M;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Storage needs no reset: decode outputs are qualified by count and gated during rst.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            instr_mem_q[wr_ptr_q] <= imem_resp_instr;
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: a memory model checks request addresses,
// a monitor checks decode-side PC/instr order against queued expectations.
module tb_fetch_queue_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [63:0] id_pc;
    logic        id_ready;

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] exp_req[$];
    logic [63:0] exp_pc[$];
    logic [31:0] exp_ins[$];

    int          mem_lat  = 1;
    int          n_acc    = 0;
    bit          mem_pend = 1'b0;
    int          mem_cnt  = 0;
    logic [63:0] mem_addr = '0;

    always #5 clk = ~clk;

    fetch_queue_unit #(.XLEN(64), .DEPTH(4), .RESET_PC(64'd0)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid), .imem_resp_instr(imem_resp_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready)
    );

    function automatic logic [31:0] ins_of(input logic [63:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_fetch(input logic [63:0] a, input bit delivered);
        exp_req.push_back(a);
        if (delivered) begin
            exp_pc.push_back(a);
            exp_ins.push_back(ins_of(a));
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    // Raise imem_req_ready until n more requests are accepted; called at posedge+1.
    task automatic accept_n(input int n);
        int tgt;
        int k;
        tgt = n_acc + n;
        k   = 0;
        imem_req_ready = 1'b1;
        while (n_acc < tgt && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        imem_req_ready = 1'b0;
        check("accept_count", 64'(n_acc), 64'(tgt));
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((exp_pc.size() != 0 || mem_pend) && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_left", 64'(exp_pc.size()), 64'd0);
    endtask

    // Instruction memory: responds mem_lat cycles after each accepted request.
    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_instr = '0;
        forever begin
            @(negedge clk);
            imem_resp_valid = 1'b0;
            if (mem_pend) begin
                if (mem_cnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_instr = ins_of(mem_addr);
                    mem_pend        = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                n_acc++;
                mem_pend = 1'b1;
                mem_addr = imem_req_addr;
                mem_cnt  = mem_lat - 1;
                if (exp_req.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL req_unexpected: got addr %h, expected no request", imem_req_addr);
                end else begin
                    check("req_addr", imem_req_addr, exp_req.pop_front());
                end
            end
        end
    end

    // Decode monitor.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && id_valid && id_ready) begin
                if (exp_pc.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL id_unexpected: got pc %h instr %h, expected none", id_pc, id_instr);
                end else begin
                    check("id_pc", id_pc, exp_pc.pop_front());
                    check("id_instr", 64'(id_instr), 64'(exp_ins.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b1;

        // Reset state
        repeat (2) at_neg();
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_id_valid", 64'(id_valid), 64'd0);
        check("rst_id_pc", id_pc, 64'd0);
        check("rst_id_instr", 64'(id_instr), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        at_neg();
        check("post_rst_req_valid", 64'(imem_req_valid), 64'd1);
        check("post_rst_req_addr", imem_req_addr, 64'h0);
        check("post_rst_id_valid", 64'(id_valid), 64'd0);
        @(posedge clk);
        #1;

        // Sequential fetch 0,4,8
        expect_fetch(64'h0, 1'b1);
        expect_fetch(64'h4, 1'b1);
        expect_fetch(64'h8, 1'b1);
        accept_n(3);
        wait_drain();

        // Redirect in S_REQ back to 0, then fill with decode stalled
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        base           = n_acc;
        expect_fetch(64'h0, 1'b1);
        expect_fetch(64'h4, 1'b1);
        expect_fetch(64'h8, 1'b1);
        expect_fetch(64'hC, 1'b1);
        imem_req_ready = 1'b1;
        repeat (12) @(posedge clk);
        at_neg();
        check("full_req_valid", 64'(imem_req_valid), 64'd0);
        check("full_accepts", 64'(n_acc - base), 64'd4);
        check("full_id_valid", 64'(id_valid), 64'd1);
        check("full_head_pc", id_pc, 64'h0);
        @(posedge clk);
        #1;
        expect_fetch(64'h10, 1'b1);
        id_ready = 1'b1;
        accept_n(1);
        wait_drain();

        // Redirect while waiting, response two cycles away: dropped
        mem_lat = 3;
        expect_fetch(64'h14, 1'b0);
        accept_n(1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h103;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        mem_lat        = 1;
        at_neg();
        check("drop_id_valid", 64'(id_valid), 64'd0);
        check("drop_req_valid", 64'(imem_req_valid), 64'd0);
        check("drop_new_pc", imem_req_addr, 64'h100);
        @(posedge clk);
        #1;
        expect_fetch(64'h100, 1'b1);
        accept_n(1);
        wait_drain();

        // Redirect coincident with response: discarded, no extra drop
        expect_fetch(64'h104, 1'b0);
        accept_n(1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        at_neg();
        check("coinc_id_valid", 64'(id_valid), 64'd0);
        check("coinc_req_valid", 64'(imem_req_valid), 64'd1);
        check("coinc_req_addr", imem_req_addr, 64'h200);
        @(posedge clk);
        #1;
        expect_fetch(64'h200, 1'b1);
        accept_n(1);
        wait_drain();

        // Memory not ready for 5 cycles: request held stable
        for (int i = 0; i < 5; i++) begin
            at_neg();
            check("stall_req_valid", 64'(imem_req_valid), 64'd1);
            check("stall_req_addr", imem_req_addr, 64'h204);
            check("stall_id_valid", 64'(id_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        expect_fetch(64'h204, 1'b1);
        accept_n(1);
        wait_drain();

        // Response-to-decode latency
        expect_fetch(64'h208, 1'b1);
        accept_n(1);
        at_neg();
        check("lat_resp_present", 64'(imem_resp_valid), 64'd1);
`ifdef FETCH_BYPASS_EN
        check("lat_resp_cycle_id_valid", 64'(id_valid), 64'd1);
        check("lat_resp_cycle_id_pc", id_pc, 64'h208);
`else
        check("lat_resp_cycle_id_valid", 64'(id_valid), 64'd0);
`endif
        at_neg();
`ifdef FETCH_BYPASS_EN
        check("lat_next_id_valid", 64'(id_valid), 64'd0);
`else
        check("lat_next_id_valid", 64'(id_valid), 64'd1);
        check("lat_next_id_pc", id_pc, 64'h208);
`endif
        @(posedge clk);
        #1;
        wait_drain();

        check("req_queue_left", 64'(exp_req.size()), 64'd0);
        check("out_queue_left", 64'(exp_pc.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
